// File: rtl/block_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// block_dispatcher_pkg
// Shared definitions for the block dispatcher slice:
//   - dispatcher FSM state encoding (localparams plus the enum built on them)
//   - default widths for block indexes and the mu (blocks per side) input
//   - clog2_min1: selector width that stays at least one bit wide
// ---------------------------------------------------------------------------
package block_dispatcher_pkg;

  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_MAX_MU_LOG  = 8;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_SELECT_ENC = 3'd1;
  localparam logic [2:0] ST_OFFER_ENC  = 3'd2;
  localparam logic [2:0] ST_DRAIN_ENC  = 3'd3;
  localparam logic [2:0] ST_FINISH_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SELECT = ST_SELECT_ENC,
    ST_OFFER  = ST_OFFER_ENC,
    ST_DRAIN  = ST_DRAIN_ENC,
    ST_FINISH = ST_FINISH_ENC
  } state_t;

  // A single CU still needs a one-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_dispatcher_cu_select.sv
// ---------------------------------------------------------------------------
// cu_select
// Combinational priority encoder: finds the lowest-numbered CU whose busy
// flag is clear.
//   busy  : per-CU busy flags
//   idx   : index of the lowest idle CU (zero when none is idle)
//   valid : at least one CU is idle
// ---------------------------------------------------------------------------
module cu_select #(
  parameter int num_cu    = 4,
  parameter int sel_width = 2
) (
  input  logic [num_cu-1:0]    busy,
  output logic [sel_width-1:0] idx,
  output logic                 valid
);

  // Priority scan from CU 0 upward; the first idle CU wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < num_cu; k++) begin
      if (!busy[k] && !valid) begin
        idx   = sel_width'(k);
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// ---------------------------------------------------------------------------
// block_dispatcher
// Hands out the mu x mu C_ij block indexes of a matrix multiply, row-major,
// to a pool of compute units (CUs), and counts completed blocks.
//   i_Clock, i_Reset       : clock, synchronous active-high reset
//   i_Start, i_mu          : start a run of mu x mu blocks (sampled in IDLE)
//   o_Row_Index/o_Column_Index : shared i/j of the block on offer
//   o_Indexes_Ready        : one-hot offer strobe to the chosen CU
//   i_Indexes_Received     : per-CU acknowledge of the offer
//   i_Result_Ready         : per-CU block-complete level
//   o_Busy, o_Done         : run in progress / one-cycle completion pulse
//   o_Blocks_Done          : completed blocks in the current/last run
// Optional: DISPATCH_PERF_COUNT_EN adds o_Cycle_Count, a saturating count
// of cycles spent with o_Busy high.
// ---------------------------------------------------------------------------
module block_dispatcher
  import block_dispatcher_pkg::*;
#(
  parameter int num_cu      = 4,
  parameter int index_width = DEFAULT_INDEX_WIDTH,
  parameter int max_mu_log  = DEFAULT_MAX_MU_LOG
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Start,
  input  logic [max_mu_log-1:0]   i_mu,
  output logic [index_width-1:0]  o_Row_Index,
  output logic [index_width-1:0]  o_Column_Index,
  output logic [num_cu-1:0]       o_Indexes_Ready,
  input  logic [num_cu-1:0]       i_Indexes_Received,
  input  logic [num_cu-1:0]       i_Result_Ready,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic [2*max_mu_log-1:0] o_Blocks_Done
`ifdef DISPATCH_PERF_COUNT_EN
  ,
  output logic [31:0]             o_Cycle_Count
`endif
);

  localparam int CW = clog2_min1(num_cu);
  localparam int BW = 2 * max_mu_log;
  localparam logic [index_width-1:0] IDX_ONE = {{(index_width-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [max_mu_log-1:0]   mu_r, mu_s;
  logic [index_width-1:0]  row_r, row_s, col_r, col_s;
  logic [num_cu-1:0]       busy_r, busy_s, ready_r, ready_s;
  logic                    run_r, run_s, done_r, done_s;
  logic [BW-1:0]           blocks_r, blocks_s, complete_cnt_s;
  logic [num_cu-1:0]       complete_s, accept_s;
  logic                    last_col_s, last_row_s;
  logic [CW-1:0]           sel_idx_s;
  logic                    sel_valid_s;

  cu_select #(
    .num_cu    (num_cu),
    .sel_width (CW)
  ) u_cu_select (
    .busy  (busy_r),
    .idx   (sel_idx_s),
    .valid (sel_valid_s)
  );

  // Completions and acceptance; a stale acknowledge while the CU still
  // reports a finished result must not be taken as a new acceptance.
  always_comb begin
    complete_s     = busy_r & i_Result_Ready;
    accept_s       = ready_r & i_Indexes_Received & ~i_Result_Ready;
    complete_cnt_s = '0;
    for (int k = 0; k < num_cu; k++) begin
      complete_cnt_s = complete_cnt_s + BW'(complete_s[k]);
    end
    last_col_s = ((32'(col_r) + 32'd1) == 32'(mu_r));
    last_row_s = ((32'(row_r) + 32'd1) == 32'(mu_r));
  end

  // Next-state and next-output logic of the dispatch FSM.
  always_comb begin
    state_s  = state_r;
    mu_s     = mu_r;
    row_s    = row_r;
    col_s    = col_r;
    busy_s   = (busy_r & ~complete_s) | accept_s;
    ready_s  = ready_r;
    run_s    = run_r;
    done_s   = 1'b0;
    blocks_s = blocks_r + complete_cnt_s;
    case (state_r)
      ST_IDLE: begin
        if (i_Start) begin
          mu_s     = i_mu;
          row_s    = '0;
          col_s    = '0;
          blocks_s = '0;
          run_s    = 1'b1;
          state_s  = (i_mu == '0) ? ST_FINISH : ST_SELECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (sel_valid_s) begin
          ready_s            = '0;
          ready_s[sel_idx_s] = 1'b1;
          state_s            = ST_OFFER;
        end else begin
          state_s = ST_SELECT;
        end
      end
      ST_OFFER: begin
        if (accept_s != '0) begin
          ready_s = '0;
          if (last_col_s && last_row_s) begin
            // Indexes hold at (mu-1, mu-1) so they never exceed mu-1.
            state_s = ST_DRAIN;
          end else if (last_col_s) begin
            col_s   = '0;
            row_s   = row_r + IDX_ONE;
            state_s = ST_SELECT;
          end else begin
            col_s   = col_r + IDX_ONE;
            state_s = ST_SELECT;
          end
        end else begin
          state_s = ST_OFFER;
        end
      end
      ST_DRAIN: begin
        if (busy_r == '0) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        done_s  = 1'b1;
        run_s   = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        ready_s = '0;
        run_s   = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r  <= ST_IDLE;
      mu_r     <= '0;
      row_r    <= '0;
      col_r    <= '0;
      busy_r   <= '0;
      ready_r  <= '0;
      run_r    <= 1'b0;
      done_r   <= 1'b0;
      blocks_r <= '0;
    end else begin
      state_r  <= state_s;
      mu_r     <= mu_s;
      row_r    <= row_s;
      col_r    <= col_s;
      busy_r   <= busy_s;
      ready_r  <= ready_s;
      run_r    <= run_s;
      done_r   <= done_s;
      blocks_r <= blocks_s;
    end
  end

  assign o_Row_Index     = row_r;
  assign o_Column_Index  = col_r;
  assign o_Indexes_Ready = ready_r;
  assign o_Busy          = run_r;
  assign o_Done          = done_r;
  assign o_Blocks_Done   = blocks_r;

`ifdef DISPATCH_PERF_COUNT_EN
  logic [31:0] cycle_r;

  // Busy-cycle counter: cleared on an accepted start, saturates, holds after done.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cycle_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && i_Start) begin
      cycle_r <= 32'd0;
    end else if (run_r && (cycle_r != 32'hFFFF_FFFF)) begin
      cycle_r <= cycle_r + 32'd1;
    end else begin
      cycle_r <= cycle_r;
    end
  end

  assign o_Cycle_Count = cycle_r;
`endif

endmodule

// File: doc/block_dispatcher.md
BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 SHALL have parameter num_cu, default 4, number of CUs served.
REQ-002 SHALL have parameter index_width, default 8, width of block row/column index.
REQ-003 SHALL have parameter max_mu_log, default 8, width of mu (blocks per matrix side).
REQ-004 SHALL have port i_Clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_Start, input, 1, begin a multiply of mu x mu blocks.
REQ-007 SHALL have port i_mu, input, max_mu_log, blocks per side; sampled only when i_Start is accepted.
REQ-008 SHALL have port o_Row_Index, output, index_width, shared i of the C_ij block offered.
REQ-009 SHALL have port o_Column_Index, output, index_width, shared j of the C_ij block offered.
REQ-010 SHALL have port o_Indexes_Ready, output, num_cu, one-hot per-CU offer strobe.
REQ-011 SHALL have port i_Indexes_Received, input, num_cu, per-CU acknowledge.
REQ-012 SHALL have port i_Result_Ready, input, num_cu, per-CU block-complete level.
REQ-013 SHALL have port o_Busy, output, 1, high from accepted start until done.
REQ-014 SHALL have port o_Done, output, 1, one-cycle pulse when all blocks are complete.
REQ-015 SHALL have port o_Blocks_Done, output, 2*max_mu_log, count of completed blocks in this run.

Function
REQ-016 SHALL implement states IDLE, SELECT, OFFER, DRAIN, FINISH.
REQ-017 IDLE: i_Start=1 SHALL latch mu, set i=j=0, clear o_Blocks_Done, assert o_Busy, and go to SELECT; mu=0 SHALL go directly to FINISH.
REQ-018 i_Start SHALL be ignored in all states other than IDLE.
REQ-019 SHALL track a per-CU busy flag; a CU is idle when its flag is 0.
REQ-020 SELECT: SHALL choose the lowest-numbered idle CU n, drive the current i/j, assert o_Indexes_Ready[n] only, and go to OFFER; if no CU is idle, it SHALL remain in SELECT with o_Indexes_Ready=0.
REQ-021 OFFER: acceptance SHALL be o_Indexes_Ready[n] & i_Indexes_Received[n] & ~i_Result_Ready[n]; a stale Received=1 while Result_Ready=1 SHALL NOT count.
REQ-022 On acceptance, SHALL set busy[n], drop o_Indexes_Ready on the next edge, and advance j; when j wraps from mu-1 to 0, i SHALL increment.
REQ-023 After acceptance of block (mu-1, mu-1), SHALL go to DRAIN; otherwise SHALL go to SELECT. Minimum spacing between offers is 2 cycles.
REQ-024 Indexes and o_Indexes_Ready SHALL stay stable throughout OFFER; there is no timeout.
REQ-025 In any state, busy[k] & i_Result_Ready[k] SHALL clear busy[k] and increment o_Blocks_Done; simultaneous completions on several CUs SHALL all be counted in the same cycle.
REQ-026 A completion and an acceptance on different CUs in the same cycle SHALL both take effect.
REQ-027 DRAIN: when all busy flags are 0, SHALL go to FINISH.
REQ-028 FINISH: SHALL pulse o_Done for one cycle, deassert o_Busy, and return to IDLE; o_Blocks_Done SHALL hold until the next start.
REQ-029 Index arithmetic SHALL be unsigned; i and j SHALL never exceed mu-1.

Reset
REQ-030 i_Reset SHALL force IDLE and clear all busy flags, and SHALL set o_Indexes_Ready=0, o_Row_Index=0, o_Column_Index=0, o_Busy=0, o_Done=0, o_Blocks_Done=0.
REQ-031 Reset mid-run SHALL abandon the run with no o_Done pulse; CU-side recovery is outside this block.

Configuration
REQ-032 With DISPATCH_PERF_COUNT_EN defined, SHALL add output o_Cycle_Count (32 bits), cleared on start and incremented each cycle while o_Busy=1, saturating at all-ones; it SHALL hold after done.
REQ-033 Without DISPATCH_PERF_COUNT_EN, SHALL omit the port and the counter entirely.

Structure
REQ-034 A shared package SHALL hold the state encoding localparams and default width constants (index_width, max_mu_log).
REQ-035 A sub-module cu_select SHALL produce the lowest idle CU index plus a valid flag from the busy vector, as a combinational priority encoder.

Verification
REQ-036 mu=2, num_cu=4, CUs acknowledge in 1 cycle and complete after 10 cycles -> offers in order (0,0),(0,1),(1,0),(1,1) to CUs 0,1,2,3; o_Done pulses once; o_Blocks_Done=4.
REQ-037 mu=3, num_cu=2 -> no more than 2 busy flags set at once; 9 offers in row-major order; o_Blocks_Done=9 at o_Done.
REQ-038 CU 0 holds Received=1 and Result_Ready=1 from a prior job -> no acceptance until Result_Ready drops; offer held stable.
REQ-039 CU 1 and CU 3 raise Result_Ready in the same cycle -> o_Blocks_Done increments by 2 in that cycle.
REQ-040 mu=0 -> o_Done pulses 2 cycles after i_Start; o_Indexes_Ready never asserted.
REQ-041 i_Reset asserted during OFFER with mu=4 -> next cycle all outputs are 0 and state is IDLE; a new i_Start then runs normally.
